conv_out_stream_buffer: RTL
===========================

Name: conv_out_stream_buffer

Overview:
- Parametrised output stage for the convolution pipeline. Sits between the MAC output and the external AXI-Stream master port.
- Replaces the vendor FIFO IP with in-house RTL:
  - generic data width and depth;
  - threshold-based upstream backpressure sized to the pipeline latency;
  - end-of-frame marking (m_last);
  - a frame-done interrupt;
  - a sticky overflow flag instead of silent data loss.

Parameters:
- DATA_W, 8, pixel width in bits.
- DEPTH, 32, FIFO entries; power of two, ≥ 4.
- PIPE_LAT, 4, maximum pixels in flight between the upstream ready and s_valid. Must be < DEPTH.
- OUT_W, 510, output pixels per row.
- OUT_H, 510, output rows per frame.

Ports:
- axi_clk  in  1  clock; all logic on the rising edge.
- axi_reset  in  1  synchronous, active-high reset.
- s_valid  in  1  convolved pixel valid. No ready path; every asserted cycle is a write attempt.
- s_data  in  DATA_W  convolved pixel.
- up_ready  out  1  permit for the upstream to accept new input pixels.
- m_valid  out  1  output pixel valid.
- m_data  out  DATA_W  output pixel.
- m_last  out  1  final pixel of the frame.
- m_ready  in  1  downstream ready.
- level  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a write was dropped.
- frame_done_intr  out  1  one-cycle pulse per completed frame.

Behaviour:
- Reset: all of the following are 0 while axi_reset is high and on the first cycle after it is released:
  - FIFO empty, read/write pointers 0;
  - level, m_valid, m_last, overflow, frame_done_intr, up_ready;
  - column and row counters.
- Ordering: strict FIFO order. No data reordering, no bypass.
- Write rule:
  - push = s_valid && (!full || pop).
  - s_valid && full && !pop drops the pixel and sets overflow. overflow stays set until reset.
- Read rule:
  - First-word fall-through: m_valid = !empty, and m_data = head entry, combinationally from storage.
  - pop = m_valid && m_ready.
  - m_data and m_last must hold stable while m_valid && !m_ready.
- Latency: a pixel written into an empty FIFO at edge N is presented on m_valid from edge N+1.
- Simultaneous push and pop: level unchanged. This is legal when full (the write is accepted) and when level = 1.
- level: registered. +1 on push only, -1 on pop only.
- up_ready: registered. up_ready <= (DEPTH - level_next) > PIPE_LAT. It deasserts early enough that PIPE_LAT in-flight pixels always fit.
- Frame counters:
  - col increments on every pop; wraps to 0 at OUT_W-1 and then increments row.
  - row wraps to 0 at OUT_H-1 on the final pixel.
- m_last = m_valid && col == OUT_W-1 && row == OUT_H-1.
- frame_done_intr: asserted for exactly one cycle, the cycle after the pop that carries m_last.
- Back-to-back frames: counters roll over with no gap cycle. frame_done_intr fires once per frame even if the next frame's first pixel pops in the same cycle the pulse is high.
- Reset mid-frame or mid-stall: FIFO contents discarded, counters cleared, no interrupt generated.

Optional Feature:
- Macro: CONV_OUT_EOL_EN.
- Defined:
  - Adds output port m_eol (1 bit) = m_valid && col == OUT_W-1. It marks every row end, including the frame end.
  - Adds a sticky status bit eol_err. It sets if a frame completes with a row count ≠ OUT_H. This is a defensive check; it is unreachable under correct counters.
- Undefined: neither port exists and there is no row-end logic beyond what m_last needs.

Decomposition:
- Package conv_stream_pkg holds:
  - default DATA_W, DEPTH, PIPE_LAT, OUT_W, OUT_H;
  - a width function for level, pointer, col and row (clog2-based);
  - a pixel type of DATA_W bits.
- One sub-module, conv_sync_fifo: pointers, storage, full/empty and level. It is FWFT and single-clock.
- The top level holds up_ready, overflow, the frame counters, m_last, the interrupt and the optional EOL logic.

Test Plan:
- Reset release with DEPTH=32, PIPE_LAT=4, m_ready=1, 10 writes of 0x01..0x0A → m_valid first rises one cycle after the first write; outputs 0x01..0x0A in order; level ends at 0; overflow=0.
- Fill with m_ready=0 → up_ready falls when level reaches 28 (free=4). Writes 29–32 are accepted. A 33rd write sets overflow=1, level stays 32, and the head is still the first pixel.
- Full FIFO, one cycle with m_ready=1 and s_valid=1 → level stays 32, no overflow, and the written pixel appears last in the drain order.
- OUT_W=4, OUT_H=2, 8 pixels streamed with random m_ready stalls → m_last only on the 8th pop and held through stalls. frame_done_intr is high for exactly one cycle after that pop.
- Two back-to-back 8-pixel frames with continuous m_ready → two frame_done_intr pulses 8 cycles apart; counters back at 0.
- Reset asserted with level=5 mid-frame → the next cycle shows m_valid=0, level=0 and no interrupt. A following full frame is counted from pixel 0.
- (CONV_OUT_EOL_EN, OUT_W=4, OUT_H=2) → m_eol on pops 4 and 8; eol_err=0.

Source files
------------

// File: rtl/conv_stream_pkg.sv
// Shared defaults, width helper and pixel type for the convolution output stream stage.
package conv_stream_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int DEPTH_DEF    = 32;
    localparam int PIPE_LAT_DEF = 4;
    localparam int OUT_W_DEF    = 510;
    localparam int OUT_H_DEF    = 510;

    typedef logic [DATA_W_DEF-1:0] pixel_t;

    // Bits needed to index n distinct values (at least one bit).
    function automatic int bits_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_sync_fifo.sv
// Single-clock first-word-fall-through FIFO: storage, pointers, full/empty and occupancy.
module conv_sync_fifo
    import conv_stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int PW     = bits_for(DEPTH),
    parameter int LW     = bits_for(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              push,
    output logic              pop,
    output logic              drop,
    output logic [LW-1:0]     level,
    output logic [LW-1:0]     level_next
);

    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              empty;
    logic              full;

    always_comb begin
        empty = (level == '0);
        full  = (level == FULL_LVL);
        pop   = !empty && rd_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push  = wr_valid && (!full || pop);
        drop  = wr_valid && full && !pop;
        level_next = level;
        if (push && !pop)
            level_next = level + LW'(1);
        else if (pop && !push)
            level_next = level - LW'(1);
    end

    assign rd_valid = !empty;
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            level <= level_next;
        end
    end

    // Storage carries no reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/conv_out_stream_buffer.sv
// Convolution output stage: FWFT FIFO with threshold backpressure, frame marking and frame-done pulse.
// Define CONV_OUT_EOL_EN to add the m_eol row-end marker and the eol_err status bit.
module conv_out_stream_buffer
    import conv_stream_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF,
    parameter int OUT_W    = OUT_W_DEF,
    parameter int OUT_H    = OUT_H_DEF
) (
    input  logic                       axi_clk,
    input  logic                       axi_reset,
    input  logic                       s_valid,
    input  logic [DATA_W-1:0]          s_data,
    output logic                       up_ready,
    output logic                       m_valid,
    output logic [DATA_W-1:0]          m_data,
    output logic                       m_last,
    input  logic                       m_ready,
    output logic [bits_for(DEPTH):0]   level,
    output logic                       overflow,
    output logic                       frame_done_intr
`ifdef CONV_OUT_EOL_EN
    ,
    output logic                       m_eol,
    output logic                       eol_err
`endif
);

    localparam int LW = bits_for(DEPTH) + 1;
    localparam int CW = bits_for(OUT_W);
    localparam int RW = bits_for(OUT_H);

    localparam logic [LW-1:0] UP_LIM   = LW'(DEPTH - PIPE_LAT);
    localparam logic [CW-1:0] COL_LAST = CW'(OUT_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(OUT_H - 1);

    logic          push;
    logic          pop;
    logic          drop;
    logic [LW-1:0] level_next;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_last;
    logic          row_last;
    logic          frame_end;

    conv_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (axi_clk),
        .rst        (axi_reset),
        .wr_valid   (s_valid),
        .wr_data    (s_data),
        .rd_ready   (m_ready),
        .rd_valid   (m_valid),
        .rd_data    (m_data),
        .push       (push),
        .pop        (pop),
        .drop       (drop),
        .level      (level),
        .level_next (level_next)
    );

    // free > PIPE_LAT  <=>  level < DEPTH - PIPE_LAT
    always_ff @(posedge axi_clk) begin
        if (axi_reset)
            up_ready <= 1'b0;
        else
            up_ready <= (level_next < UP_LIM);
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
    end

    assign col_last  = (col == COL_LAST);
    assign row_last  = (row == ROW_LAST);
    assign m_last    = m_valid && col_last && row_last;
    assign frame_end = pop && m_last;

    // Position of the head pixel within the frame; advances only on a pop.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            col <= '0;
            row <= '0;
        end else if (pop) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset)
            frame_done_intr <= 1'b0;
        else
            frame_done_intr <= frame_end;
    end

`ifdef CONV_OUT_EOL_EN
    localparam int SW = bits_for(OUT_H + 1);
    localparam logic [SW-1:0] ROWS_EXP = SW'(OUT_H - 1);

    logic [SW-1:0] rows_seen;

    assign m_eol = m_valid && col_last;

    // Independent row-end tally; a frame must close on exactly OUT_H row ends.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            rows_seen <= '0;
            eol_err   <= 1'b0;
        end else if (pop && col_last) begin
            if (frame_end) begin
                rows_seen <= '0;
                if (rows_seen != ROWS_EXP)
                    eol_err <= 1'b1;
            end else begin
                rows_seen <= rows_seen + SW'(1);
            end
        end
    end
`endif

endmodule
